fpu_sub_sched: RTL
==================

Name: fpu_sub_sched

Overview:
- Shares one double-precision subtract/normalise pipeline (fpu_sub datapath, fixed depth LATENCY, global enable stall) between NUM_REQ requesters using round-robin arbitration.
- Tracks in-flight ops with a tag pipeline and drives the datapath enable as a global stall for result back-pressure.
- fpu_op/i2d are sampled by the datapath at later stages, so ops of different mode are never mixed in flight.
- Re-times the mid-pipe shift_inexact flag so it is delivered with its result.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equal to clog2(NUM_REQ)
LATENCY, 12, datapath depth in enabled cycles from operand sample to diff_2/exponent_2 valid
INEXACT_STAGE, 7, stage at which datapath shift_inexact is valid for an op

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester op valid
req_ready  out  NUM_REQ  per-requester accept
req_opa  in  NUM_REQ*64  operand A, slice i for requester i
req_opb  in  NUM_REQ*64  operand B
req_fpu_op  in  NUM_REQ*3  op code, 000 add, 001 sub
req_i2d  in  NUM_REQ  int-to-double normalise mode
dp_enable  out  1  datapath enable (global advance)
dp_opa  out  64  operand A to datapath
dp_opb  out  64  operand B to datapath
dp_fpu_op  out  3  mode to datapath
dp_i2d  out  1  mode to datapath
dp_shift_inexact  in  1  datapath shift_inexact
res_valid  out  1  tail op valid; diff_2/exponent_2/sign of the datapath belong to it
res_id  out  ID_W  requester id of tail op
res_inexact  out  1  re-timed shift_inexact of tail op
res_ready  in  1  result consumer accept

Behaviour:
- Reset state: tag valids 0, ids 0, inexact pipe 0, rr pointer 0, cur_mode {fpu_op=000, i2d=0}, inflight count 0, inex_hold 0, fresh 0.
- Reset outputs: req_ready 0, res_valid 0, res_id 0, res_inexact 0, dp_enable 1.
- Reset mid-operation discards all in-flight ops; no result is emitted for them.
- Tag pipeline: stages 1..LATENCY, each holding {valid, id, inexact}. res_valid = valid[LATENCY].
- advance = !(valid[LATENCY] & !res_ready).
- dp_enable = advance. Bubbles also advance, so the datapath is a pure shift pipeline.
- Arbitration:
  - sel = first asserted req_valid at or after rr pointer, searching cyclically.
  - sel is eligible when inflight==0 or its {fpu_op,i2d} equals cur_mode.
  - Issue when advance & any req_valid & sel eligible: req_ready[sel]=1 (single-hot); stage1 <= {1,sel}; cur_mode <= sel mode; rr pointer <= sel+1 mod NUM_REQ.
  - Otherwise stage1 valid <= 0 on advance.
  - Ineligible sel blocks issue (no bypass to other requesters). The pipe drains, then sel issues. This gives no starvation.
- dp_opa/dp_opb: combinational mux of sel when issuing, else 0.
- dp_fpu_op/dp_i2d: sel mode when issuing, else cur_mode. Mode stays stable while any op is in flight.
- inflight count: +1 on issue, -1 on result handshake (res_valid & res_ready), both in the same cycle = unchanged. Range 0..LATENCY.
- Requesters hold valid and operands stable until req_ready. req_valid dropping without ready is a protocol violation.
- Inexact capture (datapath clears shift_inexact whenever enable is low):
  - fresh <= advance.
  - inex_cur = fresh ? dp_shift_inexact : inex_hold; inex_hold <= inex_cur every cycle.
  - On advance, stage INEXACT_STAGE+1 inexact <= inex_cur & valid[INEXACT_STAGE]. Later stages shift; stages <= INEXACT_STAGE carry 0.
  - res_inexact = inexact[LATENCY].
- Stall: with res_valid high and res_ready low, all tag state, res_* and datapath outputs hold; no issue occurs.
- Simultaneous: a result handshake and a new issue occur in the same cycle at full throughput (one op per cycle).

Test Plan:
- Single op: req0 valid, opa=0x4008000000000000 (3.0), opb=0x3FF0000000000000 (1.0), fpu_op=001, res_ready=1 -> req_ready[0] at cycle t; res_valid in cycle t+LATENCY, res_id=0, res_inexact=0, inflight returns to 0.
- Round-robin: all 4 requesters valid, same mode, continuous -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows the same order LATENCY cycles later.
- Back-pressure: res_ready low for 5 cycles with tail valid -> dp_enable low 5 cycles; res_id/res_inexact stable; no req_ready; resumes one op per cycle.
- Inexact re-timing under stall: opa=1.0, opb=0x3C30000000000000 (2^-60), with res_ready toggled so a stall lands while the op is at INEXACT_STAGE -> res_inexact=1. Same run with opb=0.5 -> res_inexact=0.
- Mode drain: req0 fpu_op=000 issued, then only req1 valid with fpu_op=001 -> req1 blocked until req0's result handshakes (inflight 0); dp_fpu_op holds 000 until req1 issue.
- Reset mid-flight: 3 ops in flight, rst pulsed 1 cycle -> res_valid 0 thereafter with no stale results; rr pointer 0; next grant goes to lowest valid index.

Source files
------------

// File: rtl/fpu_sub_sched.sv
// Round-robin scheduler sharing one fixed-latency subtract/normalise datapath
// between several requesters. A tag pipeline shadows the datapath, the datapath
// enable doubles as the global stall for result back-pressure, and the
// mid-pipe shift_inexact flag is re-timed so it leaves with its own result.
module fpu_sub_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned LATENCY       = 12,
  parameter int unsigned INEXACT_STAGE = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_opa,
  input  logic [NUM_REQ*64-1:0] req_opb,
  input  logic [NUM_REQ*3-1:0]  req_fpu_op,
  input  logic [NUM_REQ-1:0]    req_i2d,
  output logic                  dp_enable,
  output logic [63:0]           dp_opa,
  output logic [63:0]           dp_opb,
  output logic [2:0]            dp_fpu_op,
  output logic                  dp_i2d,
  input  logic                  dp_shift_inexact,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_inexact,
  input  logic                  res_ready
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  // Tag pipeline; inexact bits only exist past the stage where the flag is captured
  logic [LATENCY:1]               r_vld;
  logic [ID_W-1:0]                r_id [1:LATENCY];
  logic [LATENCY:INEXACT_STAGE+1] r_inex;

  logic [ID_W-1:0]  r_rr;
  logic [2:0]       r_cur_op;
  logic             r_cur_i2d;
  logic [CNT_W-1:0] r_inflight;
  logic             r_inex_hold;
  logic             r_fresh;

  logic             w_advance;
  logic             w_hs;
  logic             w_found;
  logic [ID_W-1:0]  w_sel;
  int unsigned      w_sel_i;
  logic [2:0]       w_sel_op;
  logic             w_sel_i2d;
  logic             w_elig;
  logic             w_issue;
  logic             w_inex_cur;

  assign w_advance = !(r_vld[LATENCY] && !res_ready);
  assign w_hs      = r_vld[LATENCY] && res_ready;

  // Cyclic search for the first valid requester at or after the rr pointer
  always_comb begin : arb_search
    logic [ID_W-1:0] idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(r_rr) + k) % NUM_REQ);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  assign w_sel_i   = 32'(w_sel);
  assign w_sel_op  = req_fpu_op[3*w_sel_i +: 3];
  assign w_sel_i2d = req_i2d[w_sel];
  // Modes may only change once the pipe is empty, since the datapath reads them late
  assign w_elig    = (r_inflight == '0) || ({w_sel_op, w_sel_i2d} == {r_cur_op, r_cur_i2d});
  assign w_issue   = !rst && w_advance && w_found && w_elig;

  assign req_ready = w_issue ? (NUM_REQ'(1) << w_sel) : '0;
  assign dp_enable = w_advance;
  assign dp_opa    = w_issue ? req_opa[64*w_sel_i +: 64] : 64'd0;
  assign dp_opb    = w_issue ? req_opb[64*w_sel_i +: 64] : 64'd0;
  assign dp_fpu_op = w_issue ? w_sel_op  : r_cur_op;
  assign dp_i2d    = w_issue ? w_sel_i2d : r_cur_i2d;

  assign res_valid   = r_vld[LATENCY];
  assign res_id      = r_id[LATENCY];
  assign res_inexact = r_inex[LATENCY];

  // Datapath zeroes shift_inexact after a stalled edge, so fall back to the held copy
  assign w_inex_cur = r_fresh ? dp_shift_inexact : r_inex_hold;

  // Tag pipeline shifts in lock-step with the datapath enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_inex <= '0;
      for (int unsigned k = 1; k <= LATENCY; k++) r_id[k] <= '0;
    end else if (w_advance) begin
      r_vld[1] <= w_issue;
      r_id[1]  <= w_sel;
      for (int unsigned k = 2; k <= LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
      r_inex[INEXACT_STAGE+1] <= w_inex_cur && r_vld[INEXACT_STAGE];
      for (int unsigned k = INEXACT_STAGE + 2; k <= LATENCY; k++) r_inex[k] <= r_inex[k-1];
    end
  end

  // Arbitration pointer, current mode, in-flight count and inexact capture state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= '0;
      r_cur_op    <= 3'b000;
      r_cur_i2d   <= 1'b0;
      r_inflight  <= '0;
      r_inex_hold <= 1'b0;
      r_fresh     <= 1'b0;
    end else begin
      r_fresh     <= w_advance;
      r_inex_hold <= w_inex_cur;
      if (w_issue) begin
        r_rr      <= ID_W'((w_sel_i + 32'd1) % NUM_REQ);
        r_cur_op  <= w_sel_op;
        r_cur_i2d <= w_sel_i2d;
      end
      if (w_issue && !w_hs)      r_inflight <= r_inflight + CNT_W'(1);
      else if (!w_issue && w_hs) r_inflight <= r_inflight - CNT_W'(1);
    end
  end

endmodule
